// File: rtl/instr_encoder_loader.sv
// Packs decoded MIPS instruction fields into 32-bit words and writes them to
// consecutive instruction-memory addresses through a stallable write port.
module instr_encoder_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_kind,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [15:0]           in_imm,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  done
);

    localparam int unsigned CountWidth = ADDR_WIDTH + 1;
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                stateNext;
    logic                  lastQ;
    logic                  lastNext;
    logic [31:0]           wdataNext;
    logic [ADDR_WIDTH-1:0] addrNext;
    logic [CountWidth-1:0] countNext;
    logic [31:0]           encWord;
    logic [5:0]            opField;
    logic [5:0]            functField;
    logic                  isRType;

    // Opcode/funct selection matching the control unit's decode table.
    always_comb begin
        opField    = 6'h00;
        functField = 6'h00;
        isRType    = 1'b1;
        case (in_kind)
            3'd0:    functField = 6'h20;
            3'd1:    functField = 6'h22;
            3'd2:    functField = 6'h24;
            3'd3:    functField = 6'h25;
            3'd4:    functField = 6'h27;
            3'd5:    begin opField = 6'h08; isRType = 1'b0; end
            3'd6:    begin opField = 6'h0D; isRType = 1'b0; end
            3'd7:    begin opField = 6'h0C; isRType = 1'b0; end
            default: functField = 6'h00;
        endcase
        encWord = isRType ? {6'h00, in_rs, in_rt, in_rd, 5'h00, functField}
                          : {opField, in_rs, in_rt, in_imm};
    end

    // Next-state and next-datapath logic.
    always_comb begin
        stateNext = state;
        lastNext  = lastQ;
        wdataNext = mem_wdata;
        addrNext  = mem_addr;
        countNext = count;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    wdataNext = encWord;
                    lastNext  = in_last;
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    addrNext  = mem_addr + ADDR_WIDTH'(1);
                    countNext = count + CountWidth'(1);
                    stateNext = (lastQ || countNext == FullCount) ? DONE : IDLE;
                end
            end
            DONE:    stateNext = DONE;
            default: stateNext = IDLE;
        endcase
    end

    // Handshake/status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lastQ     <= 1'b0;
            mem_wdata <= 32'h0;
            mem_addr  <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            full      <= 1'b0;
        end else begin
            state     <= stateNext;
            lastQ     <= lastNext;
            mem_wdata <= wdataNext;
            mem_addr  <= addrNext;
            count     <= countNext;
            in_ready  <= (stateNext == IDLE);
            mem_we    <= (stateNext == WRITE);
            done      <= (stateNext == DONE);
            full      <= (countNext == FullCount);
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a default-depth instance and a 4-word instance,
// each tracked by an abstract transaction model plus literal spot checks.
module tb_instr_encoder_loader;

    localparam int unsigned AwA = 8;
    localparam int unsigned AwB = 2;
    localparam int DepthA = 256;
    localparam int DepthB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetA, resetB, validA, validB, memReadyA, memReadyB;
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        last;

    logic           readyA, weA, fullA, doneA;
    logic [AwA-1:0] addrA;
    logic [31:0]    wdataA;
    logic [AwA:0]   countA;
    logic           readyB, weB, fullB, doneB;
    logic [AwB-1:0] addrB;
    logic [31:0]    wdataB;
    logic [AwB:0]   countB;

    instr_encoder_loader #(.ADDR_WIDTH(AwA)) dutA (
        .clk(clk), .reset(resetA), .in_valid(validA), .in_ready(readyA),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm),
        .in_last(last), .mem_we(weA), .mem_addr(addrA), .mem_wdata(wdataA),
        .mem_ready(memReadyA), .count(countA), .full(fullA), .done(doneA)
    );

    instr_encoder_loader #(.ADDR_WIDTH(AwB)) dutB (
        .clk(clk), .reset(resetB), .in_valid(validB), .in_ready(readyB),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm),
        .in_last(last), .mem_we(weB), .mem_addr(addrB), .mem_wdata(wdataB),
        .mem_ready(memReadyB), .count(countB), .full(fullB), .done(doneB)
    );

    int nCmp = 0;
    int nBad = 0;
    int cyc  = 0;

    typedef struct {
        bit          busy;
        bit          fin;
        int          cnt;
        int          addr;
        logic [31:0] word;
        bit          last;
    } model_t;

    model_t mA, mB;
    int          wrAddrA[$];
    logic [31:0] wrDataA[$];
    int          wrAddrB[$];
    logic [31:0] wrDataB[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction word from field values using plain positional arithmetic.
    function automatic logic [31:0] encode(input int k, input int s, input int t,
                                           input int d, input int i);
        longint w;
        int op;
        int fn;
        op = 0;
        fn = 0;
        case (k)
            0: fn = 32;
            1: fn = 34;
            2: fn = 36;
            3: fn = 37;
            4: fn = 39;
            5: op = 8;
            6: op = 13;
            default: op = 12;
        endcase
        w = longint'(op) * 67108864 + longint'(s) * 2097152 + longint'(t) * 65536;
        if (k < 5) w = w + longint'(d) * 2048 + longint'(fn);
        else       w = w + longint'(i);
        return 32'(w);
    endfunction

    function automatic void step(inout model_t m, input bit rst, input bit v,
                                 input bit mr, input int depth);
        if (rst) begin
            m.busy = 0; m.fin = 0; m.cnt = 0; m.addr = 0; m.word = 32'h0; m.last = 0;
            return;
        end
        if (m.fin) return;
        if (m.busy) begin
            if (mr) begin
                m.cnt++;
                m.addr = (m.addr + 1) % depth;
                m.busy = 0;
                if (m.last || m.cnt == depth) m.fin = 1;
            end
        end else if (v) begin
            m.word = encode(int'(kind), int'(rs), int'(rt), int'(rd), int'(imm));
            m.last = last;
            m.busy = 1;
        end
    endfunction

    // Model advance and write logging on the active edge.
    always @(posedge clk) begin
        cyc++;
        if (weA === 1'b1 && memReadyA === 1'b1 && resetA === 1'b0) begin
            wrAddrA.push_back(int'(addrA));
            wrDataA.push_back(wdataA);
        end
        if (weB === 1'b1 && memReadyB === 1'b1 && resetB === 1'b0) begin
            wrAddrB.push_back(int'(addrB));
            wrDataB.push_back(wdataB);
        end
        step(mA, resetA, validA, memReadyA, DepthA);
        step(mB, resetB, validB, memReadyB, DepthB);
    end

    // Every-cycle comparison against the model on the inactive edge.
    always @(negedge clk) begin
        cmp("A.in_ready",  32'(readyA), 32'(!mA.busy && !mA.fin));
        cmp("A.mem_we",    32'(weA),    32'(mA.busy));
        cmp("A.mem_addr",  32'(addrA),  32'(mA.addr));
        cmp("A.mem_wdata", wdataA,      mA.word);
        cmp("A.count",     32'(countA), 32'(mA.cnt));
        cmp("A.full",      32'(fullA),  32'(mA.cnt == DepthA));
        cmp("A.done",      32'(doneA),  32'(mA.fin));
        cmp("B.in_ready",  32'(readyB), 32'(!mB.busy && !mB.fin));
        cmp("B.mem_we",    32'(weB),    32'(mB.busy));
        cmp("B.mem_addr",  32'(addrB),  32'(mB.addr));
        cmp("B.mem_wdata", wdataB,      mB.word);
        cmp("B.count",     32'(countB), 32'(mB.cnt));
        cmp("B.full",      32'(fullB),  32'(mB.cnt == DepthB));
        cmp("B.done",      32'(doneB),  32'(mB.fin));
    end

    task automatic offer(input bit onB, input int k, input int s, input int t, input int d,
                         input int i, input bit l, input int budget, output bit acc);
        bit rdy;
        kind = 3'(k); rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = 16'(i); last = l;
        if (onB) validB = 1'b1;
        else     validA = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < budget && !acc; n++) begin
            rdy = onB ? readyB : readyA;
            @(posedge clk);
            #1;
            acc = rdy;
        end
        validA = 1'b0;
        validB = 1'b0;
        last   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int c0;
        int nw;
        resetA = 1'b1; resetB = 1'b1; validA = 1'b0; validB = 1'b0;
        memReadyA = 1'b1; memReadyB = 1'b1;
        kind = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'h0; last = 1'b0;
        tick(); tick();
        resetA = 1'b0; resetB = 1'b0;
        cmp("rst.in_ready", 32'(readyA), 32'd1);
        cmp("rst.count",    32'(countA), 32'd0);
        cmp("rst.wdata",    wdataA,      32'h0);

        // Single ADD with memory always ready.
        offer(0, 0, 1, 2, 3, 0, 0, 10, acc);
        cmp("add.accepted", 32'(acc),    32'd1);
        cmp("add.we",       32'(weA),    32'd1);
        cmp("add.addr",     32'(addrA),  32'd0);
        cmp("add.wdata",    wdataA,      32'h00221820);
        tick();
        cmp("add.count",    32'(countA), 32'd1);
        cmp("add.ready",    32'(readyA), 32'd1);

        // Back-to-back ADDI then NOR.
        offer(0, 5, 0, 8, 0, 16'h0005, 0, 10, acc);
        c0 = cyc;
        offer(0, 4, 5, 6, 4, 0, 0, 10, acc);
        cmp("b2b.spacing", 32'(cyc - c0), 32'd2);
        tick();
        cmp("b2b.nwrites", 32'(wrAddrA.size()), 32'd3);
        if (wrAddrA.size() >= 3) begin
            cmp("b2b.addr1", 32'(wrAddrA[1]), 32'd1);
            cmp("b2b.data1", wrDataA[1],      32'h20080005);
            cmp("b2b.addr2", 32'(wrAddrA[2]), 32'd2);
            cmp("b2b.data2", wrDataA[2],      32'h00A62027);
        end

        // ORI stalled by memory for three cycles.
        memReadyA = 1'b0;
        offer(0, 6, 9, 10, 0, 16'hFFFF, 0, 10, acc);
        for (int j = 0; j < 3; j++) begin
            cmp("stall.we",    32'(weA),    32'd1);
            cmp("stall.addr",  32'(addrA),  32'd3);
            cmp("stall.wdata", wdataA,      32'h352AFFFF);
            cmp("stall.count", 32'(countA), 32'd3);
            tick();
        end
        memReadyA = 1'b1;
        cmp("stall.we4",    32'(weA),    32'd1);
        cmp("stall.wdata4", wdataA,      32'h352AFFFF);
        tick();
        cmp("stall.count4", 32'(countA), 32'd4);

        // ANDI marked last, then further offers are ignored.
        offer(0, 7, 1, 1, 0, 16'h00FF, 1, 10, acc);
        tick();
        cmp("last.done",  32'(doneA),  32'd1);
        cmp("last.ready", 32'(readyA), 32'd0);
        cmp("last.data",  wdataA,      32'h302100FF);
        validA = 1'b1;
        tick(); tick(); tick();
        validA = 1'b0;
        cmp("last.nwrites", 32'(wrAddrA.size()), 32'd5);
        cmp("last.count",   32'(countA),         32'd5);

        // Reset while a write is stalled discards it.
        resetA = 1'b1; tick(); resetA = 1'b0;
        memReadyA = 1'b0;
        offer(0, 0, 7, 8, 9, 0, 0, 10, acc);
        cmp("rstw.we_before", 32'(weA), 32'd1);
        resetA = 1'b1; tick(); resetA = 1'b0;
        cmp("rstw.we",    32'(weA),    32'd0);
        cmp("rstw.count", 32'(countA), 32'd0);
        cmp("rstw.addr",  32'(addrA),  32'd0);
        cmp("rstw.ready", 32'(readyA), 32'd1);
        memReadyA = 1'b1;
        nw = wrAddrA.size();
        offer(0, 0, 1, 2, 3, 0, 0, 10, acc);
        tick();
        cmp("rstw.nwrites", 32'(wrAddrA.size()), 32'(nw + 1));
        if (wrAddrA.size() > nw) begin
            cmp("rstw.waddr", 32'(wrAddrA[nw]), 32'd0);
            cmp("rstw.wdata", wrDataA[nw],      32'h00221820);
        end

        // Four-word memory filled by SUBs; the fifth is refused.
        for (int i = 0; i < 4; i++) begin
            offer(1, 1, 1, 2, i, 0, 0, 10, acc);
            cmp("fill.accepted", 32'(acc), 32'd1);
        end
        tick();
        cmp("fill.full",  32'(fullB),  32'd1);
        cmp("fill.done",  32'(doneB),  32'd1);
        cmp("fill.count", 32'(countB), 32'd4);
        cmp("fill.addr",  32'(addrB),  32'd0);
        offer(1, 1, 1, 2, 4, 0, 0, 6, acc);
        cmp("fill.fifth_refused", 32'(acc), 32'd0);
        cmp("fill.nwrites", 32'(wrAddrB.size()), 32'd4);
        for (int i = 0; i < 4 && i < wrAddrB.size(); i++) begin
            cmp("fill.waddr", 32'(wrAddrB[i]), 32'(i));
            cmp("fill.wdata", wrDataB[i],      32'h00220022 + 32'(i) * 32'h800);
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and program loader for the single-cycle MIPS core. Accepts decoded instruction fields (kind, rs, rt, rd, imm) over a valid/ready handshake and packs each into a 32-bit MIPS word, using the same opcode/funct set the control unit decodes: R-type ADD/SUB/AND/OR/NOR, and I-type ADDI/ORI/ANDI. Writes the words to consecutive instruction-memory addresses through a stallable write port. Used by the bench and boot path to fill program memory before the core is released.

## Interface
- ADDR_WIDTH, 8, word-address width of the instruction memory; depth = 2^ADDR_WIDTH words
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept fields this cycle
- in_kind  in  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=NOR, 5=ADDI, 6=ORI, 7=ANDI
- in_rs  in  5  source register rs
- in_rt  in  5  rt (R-type source / I-type destination)
- in_rd  in  5  rd (R-type destination; ignored for I-type)
- in_imm  in  16  immediate (ignored for R-type)
- in_last  in  1  this is the final instruction of the program
- mem_we  out  1  write request to instruction memory
- mem_addr  out  ADDR_WIDTH  word address of the write
- mem_wdata  out  32  encoded instruction word
- mem_ready  in  1  memory accepts the write this cycle
- count  out  ADDR_WIDTH+1  number of words written so far
- full  out  1  all 2^ADDR_WIDTH words written
- done  out  1  program complete (last written or full)

## Operation
- Encoding, R-type: [31:26]=0, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=0, [5:0]=funct; funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, NOR 0x27.
- Encoding, I-type: [31:26]=op (ADDI 0x08, ORI 0x0D, ANDI 0x0C), [25:21]=rs, [20:16]=rt, [15:0]=imm, unmodified (no sign handling here).
- FSM states: IDLE, WRITE, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register the encoded word and in_last, then go to WRITE.
- WRITE: in_ready=0, mem_we=1, with mem_addr and mem_wdata held stable until mem_ready=1. On mem_we&&mem_ready:
  - count and mem_addr increment.
  - Go to DONE if the captured in_last was set or count reaches 2^ADDR_WIDTH; otherwise go to IDLE.
- DONE: in_ready=0, mem_we=0, done=1. Only reset leaves DONE.
- mem_addr wraps to 0 after the final word. No further writes can occur because the FSM is in DONE.
- full = (count == 2^ADDR_WIDTH). done = (state == DONE).
- Fields presented while in_ready=0 are ignored and not consumed.

## Timing
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, done=0.
- Latency: mem_we rises the cycle after the accepting edge.
- Throughput: at best one instruction per 2 cycles (accept, then write with mem_ready=1).
- in_ready is a function of registered state only, with no combinational path from in_valid or mem_ready.
- mem_ready low while in WRITE: the FSM stalls indefinitely with outputs frozen.
- in_last with a full-triggering write: both cases go to DONE; full and done assert together.
- Reset during WRITE: the pending word is discarded. The cycle after the reset edge shows mem_we=0 and count=0.
- Reset has priority over every other event in the same cycle.

## Test plan
- ADD rs=1 rt=2 rd=3, mem_ready tied high -> one cycle later, mem_we=1, mem_addr=0, mem_wdata=0x00221820; the next cycle shows count=1 and in_ready=1.
- Back-to-back ADDI rs=0 rt=8 imm=0x0005, then NOR rs=5 rt=6 rd=4 -> writes 0x20080005 at addr 0 and 0x00A62027 at addr 1, each accept spaced 2 cycles apart.
- ORI rs=9 rt=10 imm=0xFFFF with mem_ready low for 3 cycles -> mem_we, mem_addr=0, and mem_wdata=0x352AFFFF stay stable for 4 cycles; count increments only after mem_ready=1.
- ANDI rs=1 rt=1 imm=0x00FF with in_last=1 -> writes 0x302100FF; then done=1, in_ready=0, and a later in_valid produces no write.
- ADDR_WIDTH=2, five SUB instructions offered -> four writes to addrs 0..3, then full=1, done=1, count=4; the fifth is never accepted.
- Assert reset while in WRITE with mem_ready low -> next cycle mem_we=0, count=0, mem_addr=0, in_ready=1; a new ADD is then written at addr 0.
